iir_decimator_fifo: RTL and testbench

- Downstream stage of the cascaded iir_order2 filter chain.
- Takes the filtered 32-bit signed sample stream and decimates it by 2^LOG2_DECIM using a rounded boxcar average.
- Buffers the decimated samples in a small first-word-fall-through (FWFT) FIFO.
- Presents the buffered samples on a valid/ready interface to the slower consumer (file writer, DAC or host).

---
 rtl/iir_decimator_fifo_pkg.sv | 23 ++
 rtl/iir_decimator_fifo_sync_fifo_fwft.sv | 77 +++++++
 rtl/iir_decimator_fifo.sv | 118 +++++++++++
 tb/tb_iir_decimator_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_decimator_fifo_pkg.sv
// Shared definitions for the IIR decimator output stage: default sample width,
// the sample type, and helpers that size the accumulator and rounding term.
package iir_decimator_fifo_pkg;

    localparam int DW_DEFAULT = 32;

    typedef logic signed [DW_DEFAULT-1:0] sample_t;

    // Accumulator width that holds the sum of 2^log2_decim samples without overflow.
    function automatic int acc_w(input int dw, input int log2_decim);
        return dw + log2_decim;
    endfunction

    // Half of the divisor, added before the arithmetic shift so that ties round toward +inf.
    // A decimation factor of 1 needs no rounding.
    function automatic longint round_const(input int log2_decim);
        if (log2_decim == 0) begin
            return 64'sd0;
        end
        return longint'(1) << (log2_decim - 1);
    endfunction

endpackage

// File: rtl/iir_decimator_fifo_sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on dout whenever the
// FIFO holds data, and dout keeps its last value while the FIFO is empty.
module sync_fifo_fwft
    import iir_decimator_fifo_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   fill
);

    localparam int DEPTH = 1 << AW;

    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] last_q, last_d;

    logic pop_ok;
    logic push_ok;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign fill  = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = empty ? last_q : mem_q[rd_q[AW-1:0]];

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if the head leaves on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for storage, pointers and the held output; flush resets the pointers and drops any push.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        mem_d  = mem_q;
        last_d = dout;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q[AW-1:0]] = din;
                wr_d = wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            mem_q  <= '{default: '0};
            last_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            mem_q  <= mem_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/iir_decimator_fifo.sv
// Decimates the filtered sample stream by 2^LOG2_DECIM with a rounded boxcar
// average and buffers the results in a FWFT FIFO towards a slower consumer.
module iir_decimator_fifo
    import iir_decimator_fifo_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [DW-1:0]    x_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DW-1:0]    y_out,
    output logic [FIFO_AW:0] fill,
    output logic             ovf,
    input  logic             clr_ovf
);

    localparam int AW = acc_w(DW, LOG2_DECIM);
    localparam int PW = (LOG2_DECIM == 0) ? 1 : LOG2_DECIM;
    localparam logic [PW-1:0] PHASE_LAST = PW'((1 << LOG2_DECIM) - 1);
    localparam logic signed [AW-1:0] ROUND_C = AW'(round_const(LOG2_DECIM));

    logic signed [AW-1:0] acc_q, acc_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic                 pv_q, pv_d;
    logic [DW-1:0]        avg_q, avg_d;
    logic                 ovf_q, ovf_d;

    logic signed [DW-1:0] x_s;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] sum;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_fire;
    logic                 drop;

    // Sign-extend before adding; the widened accumulator cannot overflow over one frame.
    assign x_s   = x_in;
    assign x_ext = AW'(x_s);
    assign sum   = acc_q + x_ext;

    assign out_valid = !fifo_empty;
    assign pop_fire  = out_ready && out_valid;
    assign drop      = pv_q && fifo_full && !pop_fire && !flush;
    assign ovf       = ovf_q;

    // Accumulate a frame, and on its last sample form the rounded average for the one-cycle pipeline stage.
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        pv_d    = 1'b0;
        avg_d   = avg_q;
        if (flush) begin
            acc_d   = '0;
            phase_d = '0;
        end else if (in_valid) begin
            if (phase_q == PHASE_LAST) begin
                avg_d   = DW'((sum + ROUND_C) >>> LOG2_DECIM);
                pv_d    = 1'b1;
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // Sticky overflow: a dropped sample sets it even when a clear arrives on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Decimator state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            phase_q <= '0;
            pv_q    <= 1'b0;
            avg_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            pv_q    <= pv_d;
            avg_q   <= avg_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo_fwft #(
        .DW (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (pv_q),
        .pop   (out_ready),
        .din   (avg_q),
        .dout  (y_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill)
    );

endmodule

// File: tb/tb_iir_decimator_fifo.sv
// Directed bench for iir_decimator_fifo with the default parameters
// (DW=32, decimate by 4, FIFO depth 8).
module tb_iir_decimator_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] x_in;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] y_out;
    logic [3:0]  fill;
    logic        ovf;
    logic        clr_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] x0;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] x3;
        logic [31:0] y;
        string       name;
    } frame_vec_t;

    frame_vec_t vecs [8];

    iir_decimator_fifo #(
        .DW         (32),
        .LOG2_DECIM (2),
        .FIFO_AW    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .y_out     (y_out),
        .fill      (fill),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic frame_vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d,
                                      input logic [31:0] y, input string name);
        frame_vec_t v;
        v.x0 = a; v.x1 = b; v.x2 = c; v.x3 = d; v.y = y; v.name = name;
        return v;
    endfunction

    // Advance one edge and move 1 ns past it so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for exactly one edge.
    task automatic applyStimulus(input logic [31:0] x);
        in_valid = 1'b1;
        x_in     = x;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic feedFrame(input logic [31:0] x);
        for (int k = 0; k < 4; k++) applyStimulus(x);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(32'd1, 32'd2, 32'd3, 32'd4, 32'd3, "avg_1234");
        vecs[1] = mk(-32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd2, "avg_neg1234");
        vecs[2] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, "max_pos");
        vecs[3] = mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, "max_neg");
        vecs[4] = mk(32'd0, 32'd0, 32'd0, 32'd1, 32'd0, "quarter_down");
        vecs[5] = mk(32'd0, 32'd0, 32'd1, 32'd1, 32'd1, "half_up");
        vecs[6] = mk(-32'sd1, 32'd0, 32'd0, -32'sd1, 32'd0, "neg_half_up");
        vecs[7] = mk(-32'sd3, 32'd0, 32'd0, 32'd0, -32'sd1, "neg_3q");

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; x_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_y",     y_out,          32'd0);
        checkOutput("reset_fill",  32'(fill),      32'd0);
        checkOutput("reset_ovf",   32'(ovf),       32'd0);
        rst = 1'b1;
        tick();

        // Table-driven frames: latency, value, pop and hold-after-empty.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].x0);
            applyStimulus(vecs[v].x1);
            applyStimulus(vecs[v].x2);
            applyStimulus(vecs[v].x3);
            checkOutput({vecs[v].name, "_pv_stage"}, 32'(out_valid), 32'd0);
            tick();
            checkOutput({vecs[v].name, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({vecs[v].name, "_y"},     y_out,          vecs[v].y);
            checkOutput({vecs[v].name, "_fill"},  32'(fill),      32'd1);
            popOne();
            checkOutput({vecs[v].name, "_hold"},  y_out,          vecs[v].y);
        end

        // Holes between samples do not advance the phase.
        applyStimulus(32'd10);
        applyStimulus(32'd20);
        tick(); tick();
        applyStimulus(32'd30);
        tick(); tick(); tick();
        checkOutput("holes_fill_before", 32'(fill), 32'd0);
        applyStimulus(32'd40);
        tick();
        checkOutput("holes_y",    y_out,     32'd25);
        checkOutput("holes_fill", 32'(fill), 32'd1);
        tick(); tick();
        checkOutput("holes_fill_once", 32'(fill), 32'd1);
        popOne();

        // Flush mid-frame discards the partial sum and the same-cycle sample.
        applyStimulus(32'd100);
        applyStimulus(32'd100);
        flush = 1'b1; in_valid = 1'b1; x_in = 32'd999;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush_fill", 32'(fill), 32'd0);
        feedFrame(32'd4);
        tick();
        checkOutput("flush_y",    y_out,     32'd4);
        checkOutput("flush_fill_after", 32'(fill), 32'd1);
        popOne();
        checkOutput("flush_empty", 32'(fill), 32'd0);

        // Push and pop on the same edge while full: nothing is dropped.
        for (int f = 0; f < 8; f++) feedFrame(32'(11 + f));
        tick();
        checkOutput("same_edge_full", 32'(fill), 32'd8);
        feedFrame(32'd19);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("same_edge_fill", 32'(fill), 32'd8);
        checkOutput("same_edge_ovf",  32'(ovf),  32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("same_edge_drain_%0d", i), y_out, 32'(12 + i));
            tick();
        end
        out_ready = 1'b0;
        checkOutput("same_edge_empty_valid", 32'(out_valid), 32'd0);
        checkOutput("same_edge_empty_fill",  32'(fill),      32'd0);

        // Overflow: nine frames into depth eight, with clr_ovf on the dropping edge.
        for (int f = 0; f < 9; f++) feedFrame(32'(f + 1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checkOutput("ovf_fill", 32'(fill), 32'd8);
        checkOutput("ovf_set_wins", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checkOutput("ovf_cleared", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("ovf_drain_%0d", i), y_out, 32'(i + 1));
            tick();
        end
        out_ready = 1'b0;
        checkOutput("ovf_empty_valid", 32'(out_valid), 32'd0);
        checkOutput("ovf_empty_fill",  32'(fill),      32'd0);
        checkOutput("ovf_empty_hold",  y_out,          32'd8);

        // Asynchronous reset mid-frame with data buffered.
        feedFrame(32'd9);
        tick();
        checkOutput("rst_pre_fill", 32'(fill), 32'd1);
        applyStimulus(32'd7);
        applyStimulus(32'd7);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_async_y",     y_out,          32'd0);
        checkOutput("rst_async_fill",  32'(fill),      32'd0);
        #3;
        rst = 1'b1;
        tick();
        feedFrame(32'd1);
        tick();
        checkOutput("rst_new_frame_y",    y_out,     32'd1);
        checkOutput("rst_new_frame_fill", 32'(fill), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
